// File: rtl/order_tx.sv
// Order egress: buffers whole order words from the strategy core in a small FIFO
// and serializes each one MSB-first into an Avalon-ST beat stream with SOP/EOP.
module order_tx #(
  parameter int unsigned ORDER_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   order_valid_i,
  input  logic [ORDER_WIDTH-1:0] order_data_i,
  output logic                   order_ready_o,
  output logic                   tx_valid_o,
  output logic [BEAT_WIDTH-1:0]  tx_data_o,
  output logic                   tx_sop_o,
  output logic                   tx_eop_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic [31:0]            tx_order_count_o
);

  localparam int unsigned BEATS = ORDER_WIDTH / BEAT_WIDTH;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                 state_q;
  logic [ORDER_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]       beat_idx_q;
  logic [31:0]            order_cnt_q;

  logic [ORDER_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic fifo_empty, fifo_full, last_beat, last_done, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign last_beat  = (beat_idx_q == LAST_IDX);
  assign last_done  = (state_q == SEND) && tx_ready_i && last_beat;

  // Ready is a pure function of the registered fill level: a pop in the
  // same cycle never opens a slot for a pass-through push.
  assign order_ready_o = !fifo_full && !reset_i;
  assign push          = order_valid_i && order_ready_o;
  assign pop           = !fifo_empty && ((state_q == IDLE) || last_done);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= order_data_i;
  end

  // Serializer: the current beat always sits in the top BEAT_WIDTH bits of shift_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      beat_idx_q  <= '0;
      order_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            beat_idx_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            if (last_beat) begin
              order_cnt_q <= order_cnt_q + 32'd1;
              if (pop) begin
                shift_q    <= mem_q[rd_ptr_q];
                beat_idx_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              shift_q    <= shift_q << BEAT_WIDTH;
              beat_idx_q <= beat_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid_o       = (state_q == SEND);
  assign tx_data_o        = shift_q[ORDER_WIDTH-1 -: BEAT_WIDTH];
  assign tx_sop_o         = (state_q == SEND) && (beat_idx_q == '0);
  assign tx_eop_o         = (state_q == SEND) && last_beat;
  assign busy_o           = !fifo_empty || (state_q == SEND);
  assign tx_order_count_o = order_cnt_q;

endmodule

// File: tb/tb_order_tx.sv
// Directed bench for order_tx: a 2-beat instance for the main scenarios and a
// 1-beat instance for the SOP=EOP case; a negedge monitor logs beats and hold rules.
module tb_order_tx;

  logic         clk = 1'b0;
  logic         reset, order_valid, order_ready, tx_valid, tx_sop, tx_eop, tx_ready, busy;
  logic [127:0] order_data;
  logic [63:0]  tx_data;
  logic [31:0]  tx_count;

  logic         o1_valid, o1_ready, t1_valid, t1_sop, t1_eop, t1_ready, busy1;
  logic [63:0]  o1_data, t1_data;
  logic [31:0]  t1_count;

  always #5 clk = ~clk;

  order_tx #(.ORDER_WIDTH(128), .BEAT_WIDTH(64), .FIFO_DEPTH(4)) u_dut (
    .clk_i(clk), .reset_i(reset), .order_valid_i(order_valid), .order_data_i(order_data),
    .order_ready_o(order_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_sop_o(tx_sop), .tx_eop_o(tx_eop), .tx_ready_i(tx_ready), .busy_o(busy),
    .tx_order_count_o(tx_count)
  );

  order_tx #(.ORDER_WIDTH(64), .BEAT_WIDTH(64), .FIFO_DEPTH(4)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .order_valid_i(o1_valid), .order_data_i(o1_data),
    .order_ready_o(o1_ready), .tx_valid_o(t1_valid), .tx_data_o(t1_data),
    .tx_sop_o(t1_sop), .tx_eop_o(t1_eop), .tx_ready_i(t1_ready), .busy_o(busy1),
    .tx_order_count_o(t1_count)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Beat log and stall-hold monitor (samples 1 time unit after each negedge).
  logic [63:0]  bq_data[$];
  logic         bq_sop[$];
  logic         bq_eop[$];
  int           bq_cyc[$];
  logic [127:0] exp_ord[$];
  logic         stall_q = 1'b0;
  logic [63:0]  stall_data;
  logic         stall_sop, stall_eop;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (stall_q) begin
      chk("hold_valid", tx_valid, 1'b1);
      chk("hold_data", tx_data, stall_data);
      chk("hold_sop", tx_sop, stall_sop);
      chk("hold_eop", tx_eop, stall_eop);
    end
    stall_q    = tx_valid && !tx_ready && !reset;
    stall_data = tx_data;
    stall_sop  = tx_sop;
    stall_eop  = tx_eop;
    if (tx_valid && tx_ready && !reset) begin
      bq_data.push_back(tx_data);
      bq_sop.push_back(tx_sop);
      bq_eop.push_back(tx_eop);
      bq_cyc.push_back(cyc);
    end
  end

  task automatic clr_q();
    bq_data.delete(); bq_sop.delete(); bq_eop.delete(); bq_cyc.delete();
    exp_ord.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; order_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1; clr_q();
  endtask

  task automatic push_one(input logic [127:0] d);
    int n = 0;
    @(negedge clk); order_valid = 1'b1; order_data = d;
    #1;
    while (!order_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("push_ready", order_ready, 1'b1);
  endtask

  task automatic drop();
    @(negedge clk); order_valid = 1'b0;
    #1;
  endtask

  task automatic wait_count(input logic [31:0] target, input int bound);
    int n = 0;
    while (tx_count !== target && n < bound) begin @(negedge clk); #1; n++; end
    chk("wait_count", tx_count, target);
  endtask

  // Compare the logged beats against exp_ord split into (hi, lo) halves.
  task automatic check_stream(input string tag, input bit contig);
    int nb = bq_data.size();
    int ne = 2 * exp_ord.size();
    chk({tag, "_nbeats"}, 128'(nb), 128'(ne));
    for (int i = 0; i < nb && i < ne; i++) begin
      logic [127:0] o;
      o = exp_ord[i/2];
      chk($sformatf("%s_data%0d", tag, i), bq_data[i], (i % 2 == 0) ? o[127:64] : o[63:0]);
      chk($sformatf("%s_sop%0d", tag, i), bq_sop[i], (i % 2 == 0));
      chk($sformatf("%s_eop%0d", tag, i), bq_eop[i], (i % 2 == 1));
      if (contig) chk($sformatf("%s_gap%0d", tag, i), 128'(bq_cyc[i]), 128'(bq_cyc[0] + i));
    end
  endtask

  logic [127:0] dv [6];
  logic [127:0] rv [3];
  logic [127:0] q_ord, a_ord, a2_ord, b_ord;
  logic [63:0]  e1 [3];

  initial begin
    int k, n;
    dv[0] = 128'h1111111111111111_2222222222222222;
    dv[1] = 128'h3333333333333333_4444444444444444;
    dv[2] = 128'h5555555555555555_6666666666666666;
    dv[3] = 128'h7777777777777777_8888888888888888;
    dv[4] = 128'h9999999999999999_AAAAAAAAAAAAAAAA;
    dv[5] = 128'hBBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC;
    rv[0] = 128'hDEADBEEF00000001_CAFEF00D00000002;
    rv[1] = 128'hDEADBEEF00000003_CAFEF00D00000004;
    rv[2] = 128'hDEADBEEF00000005_CAFEF00D00000006;
    q_ord  = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    a_ord  = 128'hAAAA00000000000A_AAAA00000000000B;
    a2_ord = 128'hA2A2000000000001_A2A2000000000002;
    b_ord  = 128'hB0B0B0B0B0B0B0B0_B1B1B1B1B1B1B1B1;
    e1[0] = 64'h0102030405060708;
    e1[1] = 64'h1112131415161718;
    e1[2] = 64'h2122232425262728;

    reset = 1'b1; order_valid = 1'b0; order_data = '0; tx_ready = 1'b0;
    o1_valid = 1'b0; o1_data = '0; t1_ready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready", order_ready, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_sop", tx_sop, 1'b0);
    chk("rst_eop", tx_eop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", tx_data, 64'h0);
    chk("rst_count", tx_count, 32'h0);
    chk("rst1_ready", o1_ready, 1'b0);
    @(negedge clk); reset = 1'b0; tx_ready = 1'b1; #1;
    chk("post_rst_ready", order_ready, 1'b1);
    chk("post_rst1_ready", o1_ready, 1'b1);
    chk("post_rst1_valid", t1_valid, 1'b0);
    clr_q();

    // Single order: two beats MSB first, first beat two edges after acceptance
    push_one(128'h0011223344556677_8899AABBCCDDEEFF);
    drop();
    chk("t1_valid_e1", tx_valid, 1'b0);
    chk("t1_busy_e1", busy, 1'b1);
    @(negedge clk); #1;
    chk("t1_valid_b0", tx_valid, 1'b1);
    chk("t1_data_b0", tx_data, 64'h0011223344556677);
    chk("t1_sop_b0", tx_sop, 1'b1);
    chk("t1_eop_b0", tx_eop, 1'b0);
    @(negedge clk); #1;
    chk("t1_valid_b1", tx_valid, 1'b1);
    chk("t1_data_b1", tx_data, 64'h8899AABBCCDDEEFF);
    chk("t1_sop_b1", tx_sop, 1'b0);
    chk("t1_eop_b1", tx_eop, 1'b1);
    @(negedge clk); #1;
    chk("t1_valid_end", tx_valid, 1'b0);
    chk("t1_count", tx_count, 32'd1);
    chk("t1_busy_end", busy, 1'b0);
    exp_ord.push_back(128'h0011223344556677_8899AABBCCDDEEFF);
    check_stream("t1", 1'b1);

    // Backpressure: 5 accepted with tx_ready low, 6th stalls; then 12 contiguous beats
    do_reset();
    @(negedge clk); tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(dv[i]);
    @(negedge clk); order_data = dv[5]; #1;
    chk("t2_full_ready", order_ready, 1'b0);
    chk("t2_stall_valid", tx_valid, 1'b1);
    chk("t2_stall_sop", tx_sop, 1'b1);
    chk("t2_stall_data", tx_data, 64'h1111111111111111);
    chk("t2_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk); tx_ready = 1'b1;
    push_one(dv[5]);
    drop();
    wait_count(32'd6, 40);
    for (int i = 0; i < 6; i++) exp_ord.push_back(dv[i]);
    check_stream("t2", 1'b1);

    // Random tx_ready on three orders
    do_reset();
    k = 0; n = 0;
    while (tx_count !== 32'd3 && n < 300) begin
      @(negedge clk);
      tx_ready    = 1'($urandom_range(0, 1));
      order_valid = (k < 3);
      order_data  = (k < 3) ? rv[k] : '0;
      #1;
      if (order_valid && order_ready) k++;
      n++;
    end
    @(negedge clk); order_valid = 1'b0; tx_ready = 1'b1; #1;
    chk("t3_count", tx_count, 32'd3);
    for (int i = 0; i < 3; i++) exp_ord.push_back(rv[i]);
    check_stream("t3", 1'b0);

    // Reset after beat 0 of order A handshakes; queued A2 is discarded
    do_reset();
    push_one(a_ord);
    push_one(a2_ord);
    @(negedge clk); order_valid = 1'b0; #1;
    chk("t4_a_sop", tx_sop, 1'b1);
    chk("t4_a_hi", tx_data, a_ord[127:64]);
    @(negedge clk); reset = 1'b1; #1;
    chk("t4_a_eop_pend", tx_eop, 1'b1);
    @(negedge clk); #1;
    chk("t4_rst_valid", tx_valid, 1'b0);
    chk("t4_rst_eop", tx_eop, 1'b0);
    chk("t4_rst_data", tx_data, 64'h0);
    chk("t4_rst_ready", order_ready, 1'b0);
    chk("t4_rst_count", tx_count, 32'h0);
    @(negedge clk); reset = 1'b0; #1;
    chk("t4_ready", order_ready, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_valid", tx_valid, 1'b0);
    chk("t4_nbeats_a", 128'(bq_data.size()), 128'd1);
    chk("t4_no_eop_a", bq_eop.size() > 0 ? bq_eop[0] : 1'b1, 1'b0);
    clr_q();
    push_one(b_ord);
    drop();
    wait_count(32'd1, 20);
    exp_ord.push_back(b_ord);
    check_stream("t4", 1'b1);

    // Push while popping on a full FIFO is refused; accepted the next cycle
    do_reset();
    @(negedge clk); tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(dv[i]);
    @(negedge clk); order_valid = 1'b0; tx_ready = 1'b1; #1;
    chk("t5_full", order_ready, 1'b0);
    @(negedge clk); order_valid = 1'b1; order_data = q_ord; #1;
    chk("t5_pushpop_ready", order_ready, 1'b0);
    chk("t5_pushpop_eop", tx_eop, 1'b1);
    @(negedge clk); tx_ready = 1'b0; #1;
    chk("t5_after_pop_ready", order_ready, 1'b1);
    @(negedge clk); order_valid = 1'b0; #1;
    chk("t5_refull", order_ready, 1'b0);
    @(negedge clk); tx_ready = 1'b1;
    wait_count(32'd6, 40);
    for (int i = 0; i < 5; i++) exp_ord.push_back(dv[i]);
    exp_ord.push_back(q_ord);
    check_stream("t5", 1'b0);

    // Single-beat configuration: SOP and EOP on every beat, count per beat
    @(negedge clk); o1_valid = 1'b1; o1_data = e1[0];
    @(negedge clk); o1_data = e1[1];
    @(negedge clk); o1_data = e1[2]; #1;
    chk("b1_valid0", t1_valid, 1'b1);
    chk("b1_data0", t1_data, e1[0]);
    chk("b1_sop0", t1_sop, 1'b1);
    chk("b1_eop0", t1_eop, 1'b1);
    chk("b1_cnt0", t1_count, 32'd0);
    @(negedge clk); o1_valid = 1'b0; #1;
    chk("b1_data1", t1_data, e1[1]);
    chk("b1_sopeop1", {t1_sop, t1_eop}, 2'b11);
    chk("b1_cnt1", t1_count, 32'd1);
    @(negedge clk); #1;
    chk("b1_data2", t1_data, e1[2]);
    chk("b1_sopeop2", {t1_sop, t1_eop}, 2'b11);
    chk("b1_cnt2", t1_count, 32'd2);
    @(negedge clk); #1;
    chk("b1_valid_end", t1_valid, 1'b0);
    chk("b1_cnt3", t1_count, 32'd3);
    chk("b1_busy_end", busy1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
